// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder with valid/ready handshake on both sides.
// Optional status outputs (zero, overflow) are enabled by defining CLA_STATUS_EN.
module cla_pipe_adder #(
    parameter int WIDTH = 8,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef CLA_STATUS_EN
    ,
    output logic             zero,
    output logic             overflow
`endif
);

    localparam int NG = WIDTH / GROUP;

    logic             s1_valid_reg;
    logic [WIDTH-1:0] s1_p_reg;
    logic [WIDTH-1:0] s1_g_reg;
    logic             s1_cin_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_out_reg;

    logic             s1_ready;
    logic             s2_ready;
    logic [WIDTH:0]   c;
    logic [NG:0]      grp_c;
    logic [NG-1:0]    grp_p;
    logic [NG-1:0]    grp_g;
    logic [WIDTH-1:0] sum_next;

    assign s2_ready = !out_valid_reg | out_ready;
    assign s1_ready = !s1_valid_reg | s2_ready;
    assign in_ready = s1_ready & !rst;

    // Group propagate/generate and the in-group carries, each a flat two-level expression.
    generate
        for (genvar gi = 0; gi < NG; gi++) begin : g_grp
            localparam int B = gi * 4;
            logic p0, p1, p2, p3, g0, g1, g2, g3, cg;
            assign p0 = s1_p_reg[B];
            assign p1 = s1_p_reg[B+1];
            assign p2 = s1_p_reg[B+2];
            assign p3 = s1_p_reg[B+3];
            assign g0 = s1_g_reg[B];
            assign g1 = s1_g_reg[B+1];
            assign g2 = s1_g_reg[B+2];
            assign g3 = s1_g_reg[B+3];
            assign cg = grp_c[gi];

            assign grp_p[gi] = p3 & p2 & p1 & p0;
            assign grp_g[gi] = g3 | (p3 & g2) | (p3 & p2 & g1) | (p3 & p2 & p1 & g0);

            assign c[B]   = cg;
            assign c[B+1] = g0 | (p0 & cg);
            assign c[B+2] = g1 | (p1 & g0) | (p1 & p0 & cg);
            assign c[B+3] = g2 | (p2 & g1) | (p2 & p1 & g0) | (p2 & p1 & p0 & cg);
        end
    endgenerate

    always_comb begin
        grp_c    = '0;
        grp_c[0] = s1_cin_reg;
        for (int k = 0; k < NG; k++) begin
            grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
        end
    end

    assign c[WIDTH]  = grp_c[NG];
    assign sum_next  = s1_p_reg ^ c[WIDTH-1:0];

`ifdef CLA_STATUS_EN
    logic zero_reg;
    logic overflow_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s1_p_reg      <= '0;
            s1_g_reg      <= '0;
            s1_cin_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
            sum_reg       <= '0;
            carry_out_reg <= 1'b0;
`ifdef CLA_STATUS_EN
            zero_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
`endif
        end else begin
            if (s1_ready) begin
                s1_valid_reg <= in_valid;
                if (in_valid) begin
                    s1_p_reg   <= a ^ b;
                    s1_g_reg   <= a & b;
                    s1_cin_reg <= carry_in;
                end
            end
            // Stage 2 only advances when its result slot is free or being drained.
            if (s2_ready) begin
                out_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    sum_reg       <= sum_next;
                    carry_out_reg <= grp_c[NG];
`ifdef CLA_STATUS_EN
                    zero_reg      <= (sum_next == '0);
                    overflow_reg  <= c[WIDTH] ^ c[WIDTH-1];
`endif
                end
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign carry_out = carry_out_reg;
`ifdef CLA_STATUS_EN
    assign zero      = zero_reg;
    assign overflow  = overflow_reg;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: directed steps plus a random stream, outputs checked on negedge.
// Status outputs are checked when CLA_STATUS_EN is defined.
module tb_cla_pipe_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       carry_in = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] sum;
    logic       carry_out;
`ifdef CLA_STATUS_EN
    logic       zero;
    logic       overflow;
`endif

    int tests = 0;
    int fails = 0;
    int n_out = 0;
    int n_in  = 0;

    typedef struct packed {
        logic [7:0] s;
        logic       co;
        logic       z;
        logic       ov;
    } exp_t;

    exp_t sb[$];

    cla_pipe_adder #(.WIDTH(8), .GROUP(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out)
`ifdef CLA_STATUS_EN
        ,
        .zero      (zero),
        .overflow  (overflow)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        exp_t e;
        logic [8:0] full;
        full = {1'b0, av} + {1'b0, bv} + {8'b0, cv};
        e.s  = full[7:0];
        e.co = full[8];
        e.z  = (full[7:0] == 8'h00);
        e.ov = (av[7] == bv[7]) && (full[7] != av[7]);
        return e;
    endfunction

    // Output monitor: every accepted result must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL unexpected_output: observed sum=%0h expected none", sum);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sum", {24'b0, sum}, {24'b0, e.s});
                chk("carry_out", {31'b0, carry_out}, {31'b0, e.co});
`ifdef CLA_STATUS_EN
                chk("zero", {31'b0, zero}, {31'b0, e.z});
                chk("overflow", {31'b0, overflow}, {31'b0, e.ov});
`endif
                n_out++;
                $display("[TB] out #%0d sum=%02h carry_out=%0b", n_out, sum, carry_out);
            end
        end
    end

    // Present one beat and hold it until accepted; returns the number of stall cycles.
    task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic cv, output int waits);
        waits = 0;
        a = av; b = bv; carry_in = cv; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready) begin
            waits++;
            if (waits > 200) begin
                tests++;
                fails++;
                $error("FAIL send_timeout: observed in_ready=0 expected 1 within 200 cycles");
                break;
            end
            @(negedge clk);
        end
        if (in_ready) begin
            sb.push_back(model(av, bv, cv));
            n_in++;
            $display("[TB] in  #%0d a=%02h b=%02h cin=%0b", n_in, av, bv, cv);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int w;
        logic [7:0] held_sum;
        logic       held_co;

        // Reset state
        rst = 1'b1;
        idle(2);
        @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_sum", {24'b0, sum}, 32'd0);
        chk("rst_carry_out", {31'b0, carry_out}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Test 1: wraparound and two-cycle latency
        out_ready = 1'b1;
        send(8'hFF, 8'h01, 1'b0, w);
        @(negedge clk);
        chk("lat_cycle1_out_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_cycle2_out_valid", {31'b0, out_valid}, 32'd1);
        chk("t1_sum", {24'b0, sum}, 32'h00);
        chk("t1_carry_out", {31'b0, carry_out}, 32'd1);
        idle(2);

        // Test 2: full ripple through both groups, group boundary, signed overflow
        send(8'h55, 8'hAA, 1'b1, w);
        send(8'h0F, 8'h01, 1'b0, w);
        send(8'h7F, 8'h01, 1'b0, w);
        send(8'h80, 8'h80, 1'b0, w);
        send(8'h00, 8'h00, 1'b1, w);
        idle(4);

        // Test 3: 16 back-to-back random beats, no stalls allowed
        for (int i = 0; i < 16; i++) begin
            send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), w);
            chk("stream_stall", w, 32'd0);
        end
        idle(4);
        chk("stream_drained", sb.size(), 32'd0);

        // Test 4: backpressure holds two beats stable
        out_ready = 1'b0;
        send(8'h12, 8'h34, 1'b0, w);
        send(8'hF0, 8'h20, 1'b1, w);
        @(negedge clk);
        chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
        held_sum = sum;
        held_co  = carry_out;
        chk("bp_first_sum", {24'b0, sum}, 32'h46);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_hold_sum", {24'b0, sum}, {24'b0, held_sum});
            chk("bp_hold_co", {31'b0, carry_out}, {31'b0, held_co});
            chk("bp_hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        idle(4);
        chk("bp_drained", sb.size(), 32'd0);

        // Simultaneous accept and emit on a full pipeline
        send(8'h01, 8'h02, 1'b0, w);
        send(8'h03, 8'h04, 1'b1, w);
        send(8'h05, 8'h06, 1'b0, w);
        chk("full_accept_stall", w, 32'd0);
        idle(4);

        // Test 5: reset with two beats in flight discards them
        send(8'hAB, 8'hCD, 1'b0, w);
        send(8'h11, 8'h22, 1'b1, w);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_sum", {24'b0, sum}, 32'd0);
        chk("midrst_carry_out", {31'b0, carry_out}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("midrst_no_stale", {31'b0, out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;

        // Test 6: signed overflow case again after reset
        send(8'h7F, 8'h01, 1'b0, w);
        idle(4);

        chk("final_queue_empty", sb.size(), 32'd0);
        chk("final_out_count", n_out, n_in - 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
Two-stage pipelined carry-lookahead adder datapath for the 8-bit CLA.
- Stage 1 registers the operands and generates per-bit propagate/generate signals.
- Stage 2 resolves carries with 4-bit lookahead groups and registers the sum and carry-out.
- This is the sequential wrapper that feeds the group carry logic and consumes its carries.
- Uses a valid/ready handshake on input and output, so it can sit between an operand source and a result consumer.

Parameters:
- WIDTH, 8, operand width in bits; must be a multiple of 4 and at least 4.
- GROUP, 4, lookahead group size; fixed at 4, exposed only for documentation and assertions.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept an operand beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- carry_in  input  1  carry into bit 0.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts result this cycle.
- sum  output  WIDTH  result, (a+b+carry_in) mod 2^WIDTH.
- carry_out  output  1  carry out of the MSB.

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst. Both are fixed.
- Reset (rst=1 at a clock edge):
  - s1_valid, out_valid and all data registers clear to 0, so sum=0 and carry_out=0.
  - in_ready reads 0 during reset cycles and 1 on the first cycle after reset.
- Transfers: an input transfer occurs when in_valid and in_ready are both 1 at a clock edge. An output transfer occurs when out_valid and out_ready are both 1.
- Stage 1 registers a, b and carry_in, then computes p[i]=a[i]^b[i] and g[i]=a[i]&b[i], all held in s1 registers.
- Stage 2 logic:
  - Within each group: c[i+1]=g[i] | p[i]&c[i], fully expanded two-level.
  - Group signals: GP = AND of the group's p; GG = standard 4-bit lookahead generate.
  - Group carry: C[k+1] = GG[k] | GP[k]&C[k], with C[0]=carry_in.
  - sum[i]=p[i]^c[i]; carry_out=C[WIDTH/4].
- Latency: exactly 2 cycles from input transfer to out_valid=1 when there is no backpressure. Throughput is 1 beat per cycle.
- Ready chain:
  - s1_ready = !s1_valid | s2_ready.
  - s2_ready = !out_valid | out_ready.
  - in_ready = s1_ready & !rst.
  - Bubbles are collapsed.
- Backpressure: while out_valid=1 and out_ready=0, sum, carry_out and out_valid hold stable. Stage 1 holds its beat, and no beat is dropped or duplicated.
- Simultaneous events: a full pipeline with out_ready=1 and in_valid=1 accepts a new beat and emits one in the same cycle.
- Reset mid-operation: all in-flight beats are discarded, with no output after reset until new input arrives.
- Data registers load only on enable. Registers are not required to clear when not valid, except under reset.
- Arithmetic is unsigned modulo 2^WIDTH, with no saturation.

Optional Feature:
- Macro: CLA_STATUS_EN.
- When defined, two outputs are added, both registered alongside sum and both reset to 0:
  - zero (1 bit): sum==0.
  - overflow (1 bit): signed overflow, computed as c[WIDTH]^c[WIDTH-1].
- When not defined, these ports and their logic are absent. Behaviour is otherwise identical.

Test Plan:
1. Reset, then a=0xFF, b=0x01, carry_in=0 in one beat, out_ready=1 -> after 2 cycles, out_valid=1, sum=0x00, carry_out=1 (zero=1, overflow=0 if enabled).
2. a=0x55, b=0xAA, carry_in=1 -> sum=0x00, carry_out=1, which exercises a full ripple through both group carries. Also a=0x0F, b=0x01, carry_in=0 -> sum=0x10, carry_out=0, which checks the group boundary.
3. Stream 16 back-to-back random beats with out_ready=1 -> 16 results in order, each checked against a+b+cin, and in_ready stays 1.
4. Stream beats with out_ready=0 for 5 cycles -> in_ready falls after 2 beats are held, and sum/out_valid stay stable. Releasing out_ready delivers both beats in order with no loss.
5. Assert rst for 1 cycle while 2 beats are in flight -> out_valid=0 and sum=0 the next cycle, and no stale result appears afterwards.
6. With CLA_STATUS_EN defined, a=0x7F, b=0x01, carry_in=0 -> sum=0x80, overflow=1, carry_out=0.
